// File: rtl/digit_serial_cpa.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_cpa
// Brief    : Multi-cycle digit-serial carry-propagate adder. Adds two
//            WIDTH-bit operands DIGIT bits per clock. The carry between
//            digits is kept in a register, so the combinational carry chain
//            is only DIGIT bits long. An operation takes N = WIDTH/DIGIT
//            clocks and uses a start/busy/done handshake.
// Options  : `define DIGIT_SERIAL_CPA_SUB_EN adds a 'sub' input. When sub=1
//            at the accept edge, the block computes a + ~b + 1, and c_out=1
//            then means "no borrow".
// Revision : 1.0  initial release
// ============================================================================
module digit_serial_cpa #(
    parameter int WIDTH = 16,   // operand/sum width, multiple of DIGIT
    parameter int DIGIT = 4     // bits added per clock (1..WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef DIGIT_SERIAL_CPA_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    // Number of digit steps per operation and the counter that walks them.
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] c_last_digit = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    // Two-state controller.
    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_busy = 1'b1;

    // ------------------------------------------------------------------
    // State: flops (_q) and their next-state values (_d)
    // ------------------------------------------------------------------
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] a_sh_q,  a_sh_d;
    logic [WIDTH-1:0] b_sh_q,  b_sh_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [WIDTH-1:0] s_q,     s_d;
    logic             c_out_q, c_out_d;
    logic             done_q,  done_d;

    // ------------------------------------------------------------------
    // Datapath wires
    // ------------------------------------------------------------------
    logic [DIGIT-1:0] w_a_digit;
    logic [DIGIT-1:0] w_b_digit;
    logic [DIGIT:0]   w_digit_sum;    // {carry, digit}
    logic [DIGIT-1:0] w_digit;
    logic             w_carry;
    logic [WIDTH-1:0] w_acc_next;     // accumulator with new digit shifted in
    logic [WIDTH-1:0] w_b_load;       // B as it is latched at accept
    logic             w_carry_init;   // carry register value at accept

    // Operand conditioning at the accept edge: subtraction inverts B and
    // forces the initial carry to 1 (two's complement), ignoring c_in.
`ifdef DIGIT_SERIAL_CPA_SUB_EN
    assign w_b_load     = sub ? ~b : b;
    assign w_carry_init = sub ? 1'b1 : c_in;
`else
    assign w_b_load     = b;
    assign w_carry_init = c_in;
`endif

    // One DIGIT-bit slice of the adder: lowest digit of each shifted
    // operand plus the registered carry, producing a DIGIT+1-bit result.
    assign w_a_digit   = a_sh_q[DIGIT-1:0];
    assign w_b_digit   = b_sh_q[DIGIT-1:0];
    assign w_digit_sum = {1'b0, w_a_digit} + {1'b0, w_b_digit}
                       + {{DIGIT{1'b0}}, carry_q};
    assign w_digit     = w_digit_sum[DIGIT-1:0];
    assign w_carry     = w_digit_sum[DIGIT];

    // New digit enters at the top of the accumulator. After N steps the
    // first (least significant) digit has arrived at bit 0. Written as
    // shifts so the DIGIT == WIDTH case needs no special slicing.
    assign w_acc_next = (acc_q >> DIGIT) | (WIDTH'(w_digit) << (WIDTH - DIGIT));

    // Next-state logic for the controller and datapath registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        done_d  = 1'b0;   // done is a single-cycle pulse

        case (state_q)
            c_idle: begin
                // Accept also fires in the done cycle, which gives
                // back-to-back operations with no idle gap.
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = w_b_load;
                    carry_d = w_carry_init;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = c_busy;
                end
            end
            c_busy: begin
                // start is not looked at here: requests while busy are dropped.
                carry_d = w_carry;
                acc_d   = w_acc_next;
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                cnt_d   = cnt_q + c_cnt_one;
                if (cnt_q == c_last_digit) begin
                    // Result ports change only here, so partial sums
                    // never reach the display path.
                    s_d     = w_acc_next;
                    c_out_d = w_carry;
                    done_d  = 1'b1;
                    state_d = c_idle;
                end
            end
            default: begin
                state_d = c_idle;
            end
        endcase
    end

    // Register update; reset aborts any operation in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_idle;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == c_busy);
    assign done  = done_q;
    assign s     = s_q;
    assign c_out = c_out_q;

endmodule
`default_nettype wire
